pio_bank_sync_out: RTL and testbench

//  Parametrised multi-channel Avalon-MM output PIO bank, NUM_CH output registers of DATA_W bits.

---
 rtl/pio_bank_pkg.sv | 25 ++
 rtl/pio_bank_channel.sv | 66 ++++++
 rtl/pio_bank_sync_out.sv | 178 +++++++++++++++++
 tb/tb_pio_bank_sync_out.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bank_pkg.sv
// pio_bank_pkg: register map, CTRL bit positions and commit-state
// encoding shared by the pio_bank_sync_out output PIO bank.
package pio_bank_pkg;

    localparam logic [1:0] REG_SHADOW = 2'd0;
    localparam logic [1:0] REG_SET    = 2'd1;
    localparam logic [1:0] REG_CLR    = 2'd2;
    localparam logic [1:0] REG_LIVE   = 2'd3;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_SYNC   = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STATUS_ARMED = 0;

    typedef enum logic {
        ST_IDLE,
        ST_ARMED
    } commit_state_t;

endpackage

// File: rtl/pio_bank_channel.sv
// pio_bank_channel: one CPU shadow register and its live output
// register, with plain/set/clear shadow updates and live loading.
module pio_bank_channel
    import pio_bank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              auto_i,
    input  logic              commit_i,
    output logic [DATA_W-1:0] shadow_o,
    output logic [DATA_W-1:0] live_o,
    output logic              load_o
);

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] live_q, live_d;
    logic              upd;

    assign upd = wr_i | set_i | clr_i;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_i) begin
            shadow_d = wd_i;
        end else if (set_i) begin
            shadow_d = shadow_q | wd_i;
        end else if (clr_i) begin
            shadow_d = shadow_q & ~wd_i;
        end
    end

    // A commit takes the registered shadow, so a write on the same
    // edge only lands in the shadow.
    always_comb begin
        live_d = live_q;
        load_o = 1'b0;
        if (commit_i) begin
            live_d = shadow_q;
            load_o = 1'b1;
        end else if (auto_i && upd) begin
            live_d = shadow_d;
            load_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= RESET_VAL;
            live_q   <= RESET_VAL;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign shadow_o = shadow_q;
    assign live_o   = live_q;

endmodule

// File: rtl/pio_bank_sync_out.sv
// pio_bank_sync_out: Avalon-MM multi-channel output PIO bank with
// atomic commit; PIO_BANK_SYNC_EN enables deferred commit on sync_tick.
module pio_bank_sync_out
    import pio_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] RESET_VAL = '0,
    localparam int         AW        = $clog2(NUM_CH + 1) + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic                       sync_tick,
    output logic [NUM_CH*DATA_W-1:0]   out_port,
    output logic                       update_strobe,
    output logic                       armed
);

    localparam int             SW       = AW - 2;
    localparam logic [SW-1:0]  SEL_CTRL = SW'(NUM_CH);

    logic              we;
    logic [SW-1:0]     sel;
    logic [1:0]        rsel;
    logic [DATA_W-1:0] wd;
    logic              ctrl_we;
    logic              wd_auto;
    logic              wd_commit;
    logic              wd_abort;
    logic              wd_sync;

    assign we        = chipselect & ~write_n;
    assign sel       = address[AW-1:2];
    assign rsel      = address[1:0];
    assign wd        = writedata[DATA_W-1:0];
    assign ctrl_we   = we && (sel == SEL_CTRL) && (rsel == REG_CTRL);
    assign wd_auto   = writedata[CTRL_AUTO];
    assign wd_commit = writedata[CTRL_COMMIT];
    assign wd_abort  = writedata[CTRL_ABORT];
    assign wd_sync   = writedata[CTRL_SYNC];

    logic              auto_q, auto_d;
    logic              strobe_q;
    logic              commit_all;
    logic              sync_mode;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] ch_load;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [DATA_W-1:0] live   [NUM_CH];

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            assign ch_hit[c] = we && (sel == SW'(c));

            pio_bank_channel #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VAL[DATA_W-1:0])
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .wr_i     (ch_hit[c] && (rsel == REG_SHADOW)),
                .set_i    (ch_hit[c] && (rsel == REG_SET)),
                .clr_i    (ch_hit[c] && (rsel == REG_CLR)),
                .wd_i     (wd),
                .auto_i   (auto_q),
                .commit_i (commit_all),
                .shadow_o (shadow[c]),
                .live_o   (live[c]),
                .load_o   (ch_load[c])
            );

            assign out_port[c*DATA_W +: DATA_W] = live[c];
        end
    endgenerate

    // COMMIT/SYNC_MODE are judged against the AUTO value being written.
    assign auto_d = ctrl_we ? wd_auto : auto_q;

`ifdef PIO_BANK_SYNC_EN
    commit_state_t state_q, state_d;
    logic          sync_q, sync_d;
    logic          armed_q;

    always_comb begin
        state_d    = state_q;
        commit_all = 1'b0;
        sync_d     = ctrl_we ? wd_sync : sync_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_we && !wd_auto && wd_commit && !wd_abort) begin
                    if (wd_sync) begin
                        state_d = ST_ARMED;
                    end else begin
                        commit_all = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (ctrl_we && (wd_auto || wd_abort)) begin
                    state_d = ST_IDLE;
                end else if (sync_tick) begin
                    commit_all = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sync_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            armed_q <= (state_d == ST_ARMED);
        end
    end

    assign armed     = armed_q;
    assign sync_mode = sync_q;
`else
    assign commit_all = ctrl_we && !wd_auto && wd_commit && !wd_abort;
    assign armed      = 1'b0;
    assign sync_mode  = 1'b0;
`endif

    logic unused_w;
    assign unused_w = ^{writedata, wd_sync, sync_tick};

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            auto_q   <= auto_d;
            strobe_q <= |ch_load;
        end
    end

    assign update_strobe = strobe_q;

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SW'(i)) begin
                case (rsel)
                    REG_SHADOW: rdata = 32'(shadow[i]);
                    REG_LIVE:   rdata = 32'(live[i]);
                    default:    rdata = '0;
                endcase
            end
        end
        if (sel == SEL_CTRL) begin
            case (rsel)
                REG_CTRL: begin
                    rdata[CTRL_AUTO] = auto_q;
                    rdata[CTRL_SYNC] = sync_mode;
                end
                REG_STATUS: rdata[STATUS_ARMED] = armed;
                default:    rdata = '0;
            endcase
        end
    end

    assign readdata = rdata;

endmodule

// File: tb/tb_pio_bank_sync_out.sv
// tb_pio_bank_sync_out: directed and random checks of the PIO bank
// against a register-map level reference model.
module tb_pio_bank_sync_out;

    localparam int          NUM_CH    = 4;
    localparam int          DATA_W    = 16;
    localparam logic [31:0] RESET_VAL = 32'h0000_5A5A;
    localparam int          AW        = $clog2(NUM_CH + 1) + 2;
    localparam int          OW        = NUM_CH * DATA_W;
`ifdef PIO_BANK_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  address;
    logic           chipselect;
    logic           write_n;
    logic [31:0]    writedata;
    logic [31:0]    readdata;
    logic           sync_tick;
    logic [OW-1:0]  out_port;
    logic           update_strobe;
    logic           armed;

    always #5 clk = ~clk;

    pio_bank_sync_out #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .sync_tick     (sync_tick),
        .out_port      (out_port),
        .update_strobe (update_strobe),
        .armed         (armed)
    );

    logic [DATA_W-1:0] m_sh [NUM_CH];
    logic [DATA_W-1:0] m_lv [NUM_CH];
    bit                m_auto, m_sync, m_armed, m_load;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh[i] = RESET_VAL[DATA_W-1:0];
            m_lv[i] = RESET_VAL[DATA_W-1:0];
        end
        m_auto  = 0;
        m_sync  = 0;
        m_armed = 0;
        m_load  = 0;
    endtask

    function automatic logic [OW-1:0] m_out();
        logic [OW-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_lv[i];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input int sel, input int rg);
        logic [31:0] r = '0;
        if (sel < NUM_CH) begin
            if (rg == 0) r = 32'(m_sh[sel]);
            if (rg == 3) r = 32'(m_lv[sel]);
        end else if (sel == NUM_CH) begin
            if (rg == 0) begin
                r[1] = m_auto;
                r[2] = m_sync;
            end
            if (rg == 1) r[0] = m_armed;
        end
        return r;
    endfunction

    // Effect of one clock edge on the register map.
    task automatic m_edge(input bit we, input int sel, input int rg,
                          input logic [31:0] wdat, input bit tick);
        bit                commit = 0;
        logic [DATA_W-1:0] d = wdat[DATA_W-1:0];
        logic [DATA_W-1:0] nv;
        m_load = 0;
        if (we && sel == NUM_CH && rg == 0) begin
            if (m_armed) begin
                if (wdat[1] || wdat[3]) begin
                    m_armed = 0;
                end else if (tick) begin
                    commit  = 1;
                    m_armed = 0;
                end
            end else if (!wdat[1] && wdat[0] && !wdat[3]) begin
                if (SYNC_EN && wdat[2]) m_armed = 1;
                else commit = 1;
            end
            m_auto = wdat[1];
            m_sync = SYNC_EN && wdat[2];
        end else if (m_armed && tick) begin
            commit  = 1;
            m_armed = 0;
        end
        if (commit) begin
            for (int i = 0; i < NUM_CH; i++) m_lv[i] = m_sh[i];
            m_load = 1;
        end
        if (we && sel < NUM_CH && rg < 3) begin
            nv = d;
            if (rg == 1) nv = m_sh[sel] | d;
            if (rg == 2) nv = m_sh[sel] & ~d;
            m_sh[sel] = nv;
            if (m_auto) begin
                m_lv[sel] = nv;
                m_load    = 1;
            end
        end
    endtask

    task automatic cyc(input bit cs, input bit wr, input int sel,
                       input int rg, input logic [31:0] wdat,
                       input bit tick);
        @(negedge clk);
        chipselect = cs;
        write_n    = ~wr;
        address    = AW'(sel * 4 + rg);
        writedata  = wdat;
        sync_tick  = tick;
        #1;
        chk("readdata", readdata, m_read(sel, rg));
        @(posedge clk);
        m_edge(cs & wr, sel, rg, wdat, tick);
        #1;
        chk("out_port", out_port, m_out());
        chk("update_strobe", update_strobe, m_load);
        chk("armed", armed, m_armed);
    endtask

    task automatic wr(input int sel, input int rg, input logic [31:0] d);
        cyc(1'b1, 1'b1, sel, rg, d, 1'b0);
    endtask

    task automatic rd(input int sel, input int rg);
        cyc(1'b1, 1'b0, sel, rg, 32'h0, 1'b0);
    endtask

    task automatic idle(input bit tick);
        cyc(1'b0, 1'b0, 0, 0, 32'h0, tick);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        sync_tick  = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        chk("rst_out_port", out_port, m_out());
        chk("rst_strobe", update_strobe, 1'b0);
        chk("rst_armed", armed, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] rst_rep;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        sync_tick  = 1'b0;
        m_reset();

        do_reset();
        rst_rep = {NUM_CH{RESET_VAL[DATA_W-1:0]}};
        chk("t1_out_rep", out_port, rst_rep);
        for (int i = 0; i < NUM_CH; i++) begin
            rd(i, 0);
            chk("t1_shadow", readdata, 32'h5A5A);
            rd(i, 3);
        end

        wr(NUM_CH, 0, 32'h0);
        wr(1, 0, 32'h0000_00F0);
        wr(1, 1, 32'h0000_000F);
        wr(1, 2, 32'h0000_0030);
        rd(1, 0);
        chk("t2_shadow", readdata, 32'hCF);
        chk("t2_live_hold", out_port[DATA_W +: DATA_W], 16'h5A5A);
        rd(1, 1);
        wr(NUM_CH, 0, 32'h1);
        chk("t2_live", out_port[DATA_W +: DATA_W], 16'h00CF);
        chk("t2_strobe", update_strobe, 1'b1);
        idle(1'b0);

`ifdef PIO_BANK_SYNC_EN
        wr(NUM_CH, 0, 32'h4);
        wr(0, 0, 32'hA5);
        wr(NUM_CH, 0, 32'h5);
        chk("t3_armed", armed, 1'b1);
        rd(NUM_CH, 1);
        repeat (10) idle(1'b0);
        idle(1'b1);
        chk("t3_live", out_port[DATA_W-1:0], 16'h00A5);
        idle(1'b0);

        wr(0, 0, 32'h3C);
        wr(NUM_CH, 0, 32'h5);
        cyc(1'b1, 1'b1, NUM_CH, 0, 32'h8, 1'b1);
        chk("t4_abort_live", out_port[DATA_W-1:0], 16'h00A5);
        idle(1'b1);

        wr(NUM_CH, 0, 32'h5);
        do_reset();
        idle(1'b1);
`endif

        wr(NUM_CH, 0, 32'h2);
        wr(2, 0, 32'h1234);
        chk("t5_live", out_port[2*DATA_W +: DATA_W], 16'h1234);
        idle(1'b0);
        rd(NUM_CH + 1, 0);
        chk("t5_hole", readdata, 32'h0);

        wr(NUM_CH, 0, 32'h0);
        wr(0, 0, 32'h77);
        wr(NUM_CH, 0, 32'h5);
`ifndef PIO_BANK_SYNC_EN
        chk("t6_commit", out_port[DATA_W-1:0], 16'h0077);
        rd(NUM_CH, 0);
        chk("t6_ctrl", readdata, 32'h0);
        idle(1'b1);
`endif

        for (int n = 0; n < 600; n++) begin
            int          sel;
            int          rg;
            logic [31:0] d;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                sel = ($urandom_range(0, 3) == 0) ? NUM_CH
                                                  : $urandom_range(0, 7);
                rg  = $urandom_range(0, 3);
                d   = $urandom;
                if (sel == NUM_CH) begin
                    d = d & 32'hF;
                    if (d[0] && d[3]) d[3] = 1'b0;
                end
                cyc($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                    sel, rg, d, $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
